// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: Mem_size encodings, FSM state
// encodings and small helpers for alignment checks and store lane placement.
package lsu_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE   = 2'b00,
    SIZE_HALF   = 2'b01,
    SIZE_WORD   = 2'b10,
    SIZE_WORD_X = 2'b11   // reserved encoding, behaves as a word access
  } mem_size_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    DONE = 2'b10
  } lsu_state_e;

  // Halfwords need an even address, words a 4-byte aligned one.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
    logic mis;
    case (mem_size_e'(size))
      SIZE_BYTE: mis = 1'b0;
      SIZE_HALF: mis = lo[0];
      default:   mis = (lo != 2'b00);
    endcase
    return mis;
  endfunction

  function automatic logic [3:0] byte_enables(input logic [1:0] size, input logic [1:0] lo);
    logic [3:0] be;
    case (mem_size_e'(size))
      SIZE_BYTE: be = 4'b0001 << lo;
      SIZE_HALF: be = 4'b0011 << lo;
      default:   be = 4'b1111;
    endcase
    return be;
  endfunction

  // Replicate the store datum across all lanes; bus_be picks the live ones.
  function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] data);
    logic [31:0] w;
    case (mem_size_e'(size))
      SIZE_BYTE: w = {4{data[7:0]}};
      SIZE_HALF: w = {2{data[15:0]}};
      default:   w = data;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load lane selection and extension (combinational).
//   rdata_i    : raw 32-bit bus read data
//   addr_lo_i  : byte offset of the access within the word
//   size_i     : Mem_size encoding of the access
//   unsigned_i : 1 = zero-extend, 0 = sign-extend
//   data_o     : aligned, extended load result
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  output logic [31:0] data_o
);

  logic [31:0] shifted;
  logic        sign_b;
  logic        sign_h;

  // Little-endian: move the addressed byte/half down to bit 0.
  assign shifted = rdata_i >> {addr_lo_i, 3'b000};
  assign sign_b  = ~unsigned_i & shifted[7];
  assign sign_h  = ~unsigned_i & shifted[15];

  always_comb begin
    data_o = rdata_i;
    case (mem_size_e'(size_i))
      SIZE_BYTE: data_o = {{24{sign_b}}, shifted[7:0]};
      SIZE_HALF: data_o = {{16{sign_h}}, shifted[15:0]};
      default:   data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: turns execute-stage memory requests into single-beat bus
// transactions, stalls the pipeline while a transaction is outstanding and
// returns aligned load data with a completion pulse.
//   clock, reset              : clock, synchronous active-high reset
//   Mem_read/Mem_write        : load/store request (store wins if both)
//   Mem_size/Mem_unsigned     : access size, load extension mode
//   ALU_Result/Read_data_2    : byte address, store data
//   Mem_stall                 : pipeline hold
//   Mem_data/Mem_valid        : load result and completion pulse
//   Addr_err/Bus_err          : misalignment / bus timeout pulses
//   bus_*                     : word-aligned request/ack data bus
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        Mem_read,
  input  logic        Mem_write,
  input  logic [1:0]  Mem_size,
  input  logic        Mem_unsigned,
  input  logic [31:0] ALU_Result,
  input  logic [31:0] Read_data_2,
  output logic        Mem_stall,
  output logic [31:0] Mem_data,
  output logic        Mem_valid,
  output logic        Addr_err,
  output logic        Bus_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  lsu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic        req_any;
  logic        misaligned;
  logic        accept;
  logic        ack_seen;
  logic        timed_out;
  logic [31:0] load_data;

  logic        bus_req_q;
  logic        bus_we_q;
  logic [31:0] bus_addr_q;
  logic [31:0] bus_wdata_q;
  logic [3:0]  bus_be_q;
  logic [1:0]  addr_lo_q;
  logic [1:0]  size_q;
  logic        unsigned_q;
  logic [31:0] mem_data_q;
  logic        mem_valid_q;
  logic        addr_err_q;
  logic        bus_err_q;

  assign req_any    = Mem_read | Mem_write;
  assign misaligned = is_misaligned(Mem_size, ALU_Result[1:0]);
  assign accept     = (state_q == IDLE) && req_any && !misaligned;
  assign ack_seen   = (state_q == REQ) && bus_ack;
  // Last permitted REQ cycle without ack; an ack in that same cycle still wins.
  assign timed_out  = (state_q == REQ) && !bus_ack && (cnt_q == CNT_W'(TIMEOUT - 1));

  // Stall is raised in the accepting cycle itself, before state changes.
  assign Mem_stall  = !reset && (accept || (state_q == REQ));

  lsu_load_align u_align (
    .rdata_i    (bus_rdata),
    .addr_lo_i  (addr_lo_q),
    .size_i     (size_q),
    .unsigned_i (unsigned_q),
    .data_o     (load_data)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = REQ;
          cnt_d   = '0;
        end
      end
      REQ: begin
        if (bus_ack || timed_out) state_d = DONE;
        else                      cnt_d   = cnt_q + 1'b1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_be_q    <= '0;
      addr_lo_q   <= '0;
      size_q      <= '0;
      unsigned_q  <= 1'b0;
      mem_data_q  <= '0;
      mem_valid_q <= 1'b0;
      addr_err_q  <= 1'b0;
      bus_err_q   <= 1'b0;
    end else begin
      mem_valid_q <= 1'b0;
      addr_err_q  <= (state_q == IDLE) && req_any && misaligned;
      bus_err_q   <= 1'b0;

      if (accept) begin
        bus_req_q   <= 1'b1;
        bus_we_q    <= Mem_write;
        bus_addr_q  <= {ALU_Result[31:2], 2'b00};
        bus_be_q    <= byte_enables(Mem_size, ALU_Result[1:0]);
        bus_wdata_q <= store_lanes(Mem_size, Read_data_2);
        addr_lo_q   <= ALU_Result[1:0];
        size_q      <= Mem_size;
        unsigned_q  <= Mem_unsigned;
      end

      if (ack_seen) begin
        bus_req_q   <= 1'b0;
        mem_valid_q <= 1'b1;
        mem_data_q  <= bus_we_q ? '0 : load_data;
      end else if (timed_out) begin
        bus_req_q   <= 1'b0;
        mem_valid_q <= 1'b1;
        bus_err_q   <= 1'b1;
        mem_data_q  <= '0;
      end
    end
  end

  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign bus_be    = bus_be_q;
  assign Mem_data  = mem_data_q;
  assign Mem_valid = mem_valid_q;
  assign Addr_err  = addr_err_q;
  assign Bus_err   = bus_err_q;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        Mem_read, Mem_write, Mem_unsigned;
  logic [1:0]  Mem_size;
  logic [31:0] ALU_Result, Read_data_2;
  logic        Mem_stall, Mem_valid, Addr_err, Bus_err;
  logic [31:0] Mem_data;
  logic        bus_req, bus_we, bus_ack;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_be;

  load_store_unit #(.TIMEOUT(16)) dut (
    .clock(clock), .reset(reset),
    .Mem_read(Mem_read), .Mem_write(Mem_write), .Mem_size(Mem_size),
    .Mem_unsigned(Mem_unsigned), .ALU_Result(ALU_Result), .Read_data_2(Read_data_2),
    .Mem_stall(Mem_stall), .Mem_data(Mem_data), .Mem_valid(Mem_valid),
    .Addr_err(Addr_err), .Bus_err(Bus_err),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_be(bus_be), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  always #5 clock = ~clock;

  int unsigned cyc = 0;
  always @(posedge clock) cyc++;

  typedef struct {
    string       name;
    logic        is_addr_err;
    logic        bus_err;
    logic [31:0] data;
    int unsigned at_cyc;
  } resp_t;

  typedef struct {
    string       name;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        chk_wdata;
    logic [3:0]  be;
    int unsigned len;
  } bus_t;

  resp_t resp_q[$];
  bus_t  bus_q[$];
  int    n_cmp = 0;
  int    n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents bus or result activity.
  bit          in_bus = 0;
  int unsigned hi_cnt;
  bus_t        cur;
  resp_t       r;
  logic [31:0] cap_addr, cap_wdata;
  logic [3:0]  cap_be;
  logic        cap_we;

  always @(negedge clock) begin
    if (bus_req && !in_bus) begin
      in_bus = 1;
      hi_cnt = 1;
      cap_addr = bus_addr; cap_wdata = bus_wdata; cap_be = bus_be; cap_we = bus_we;
      if (bus_q.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL unexpected_bus_req: got bus_req=1 at cycle %0d expected 0", cyc);
        cur.name = "stray"; cur.len = 0; cur.chk_wdata = 0;
      end else begin
        cur = bus_q.pop_front();
        check({cur.name, "_we"},   {31'b0, bus_we}, {31'b0, cur.we});
        check({cur.name, "_addr"}, bus_addr, cur.addr);
        check({cur.name, "_be"},   {28'b0, bus_be}, {28'b0, cur.be});
        if (cur.chk_wdata) check({cur.name, "_wdata"}, bus_wdata, cur.wdata);
      end
    end else if (bus_req && in_bus) begin
      hi_cnt++;
      check({cur.name, "_stable"}, {bus_addr[31:1], bus_we} ^ {bus_wdata[31:4], bus_be},
            {cap_addr[31:1], cap_we} ^ {cap_wdata[31:4], cap_be});
    end else if (!bus_req && in_bus) begin
      in_bus = 0;
      check({cur.name, "_req_cycles"}, hi_cnt, cur.len);
    end

    if (Mem_valid || Addr_err || Bus_err) begin
      if (resp_q.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL unexpected_response: got valid=%0b addr_err=%0b bus_err=%0b at cycle %0d expected none",
                 Mem_valid, Addr_err, Bus_err, cyc);
      end else begin
        r = resp_q.pop_front();
        check({r.name, "_cycle"}, cyc, r.at_cyc);
        if (r.is_addr_err) begin
          check({r.name, "_addr_err"}, {30'b0, Addr_err, Mem_valid}, 32'h2);
        end else begin
          check({r.name, "_valid"},   {30'b0, Mem_valid, Bus_err}, {30'b0, 1'b1, r.bus_err});
          check({r.name, "_data"},    Mem_data, r.data);
        end
      end
    end
  end

  task automatic drive_req(input logic rd, input logic wr, input logic [1:0] size,
                           input logic uns, input logic [31:0] addr, input logic [31:0] wdata);
    Mem_read = rd; Mem_write = wr; Mem_size = size; Mem_unsigned = uns;
    ALU_Result = addr; Read_data_2 = wdata;
  endtask

  task automatic idle_inputs();
    Mem_read = 0; Mem_write = 0;
  endtask

  // Full transaction: ack arrives ack_wait cycles after the first REQ cycle.
  task automatic do_xfer(input string name, input logic rd, input logic wr,
                         input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input int unsigned ack_wait, input logic [31:0] rdata,
                         input logic [31:0] exp_addr, input logic [3:0] exp_be,
                         input logic [31:0] exp_wdata, input logic [31:0] exp_data);
    bus_t  b;
    resp_t e;
    @(posedge clock); #2;
    b.name = name; b.we = wr; b.addr = exp_addr; b.wdata = exp_wdata;
    b.chk_wdata = wr; b.be = exp_be; b.len = ack_wait + 1;
    bus_q.push_back(b);
    e.name = name; e.is_addr_err = 0; e.bus_err = 0; e.data = exp_data;
    e.at_cyc = cyc + 2 + ack_wait;
    resp_q.push_back(e);
    drive_req(rd, wr, size, uns, addr, wdata);
    #1 check({name, "_stall_accept"}, {31'b0, Mem_stall}, 32'd1);
    @(posedge clock); #2;
    idle_inputs();
    #1 check({name, "_stall_req"}, {31'b0, Mem_stall}, 32'd1);
    repeat (ack_wait) begin @(posedge clock); #2; end
    bus_ack = 1; bus_rdata = rdata;
    @(posedge clock); #2;
    bus_ack = 0; bus_rdata = 32'h5A5A_5A5A;
    #1 check({name, "_stall_done"}, {31'b0, Mem_stall}, 32'd0);
    @(posedge clock); #2;
    #1 check({name, "_hold"}, Mem_data, exp_data);
  endtask

  task automatic do_misaligned(input string name, input logic rd, input logic wr,
                               input logic [1:0] size, input logic [31:0] addr);
    resp_t e;
    @(posedge clock); #2;
    e.name = name; e.is_addr_err = 1; e.bus_err = 0; e.data = 0; e.at_cyc = cyc + 1;
    resp_q.push_back(e);
    drive_req(rd, wr, size, 1'b0, addr, 32'hFFFF_FFFF);
    #1 check({name, "_stall"}, {31'b0, Mem_stall}, 32'd0);
    @(posedge clock); #2;
    idle_inputs();
    #1 check({name, "_stall_next"}, {31'b0, Mem_stall}, 32'd0);
    repeat (2) @(posedge clock);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_t  b;
    resp_t e;
    reset = 1; bus_ack = 0; bus_rdata = 0;
    drive_req(0, 0, 2'b10, 0, 0, 0);
    repeat (3) @(posedge clock);
    #2;
    check("reset_bus", {bus_req, bus_we, bus_be, 26'b0}, 32'h0);
    check("reset_addr", bus_addr, 32'h0);
    check("reset_wdata", bus_wdata, 32'h0);
    check("reset_result", {Mem_valid, Addr_err, Bus_err, Mem_stall, 28'b0}, 32'h0);
    check("reset_data", Mem_data, 32'h0);
    reset = 0;

    do_xfer("sw_104",  0, 1, 2'b10, 0, 32'h0000_0104, 32'hDEAD_BEEF, 0, 32'h0,
            32'h0000_0104, 4'b1111, 32'hDEAD_BEEF, 32'h0);
    do_xfer("lb_103",  1, 0, 2'b00, 0, 32'h0000_0103, 32'h0, 0, 32'h80FF_FFFF,
            32'h0000_0100, 4'b1000, 32'h0, 32'hFFFF_FF80);
    do_xfer("lbu_103", 1, 0, 2'b00, 1, 32'h0000_0103, 32'h0, 0, 32'h80FF_FFFF,
            32'h0000_0100, 4'b1000, 32'h0, 32'h0000_0080);
    do_xfer("sh_102",  0, 1, 2'b01, 0, 32'h0000_0102, 32'h0000_ABCD, 0, 32'h0,
            32'h0000_0100, 4'b1100, 32'hABCD_ABCD, 32'h0);
    do_xfer("lh_102",  1, 0, 2'b01, 0, 32'h0000_0102, 32'h0, 2, 32'h8001_1234,
            32'h0000_0100, 4'b1100, 32'h0, 32'hFFFF_8001);
    do_xfer("lhu_100", 1, 0, 2'b01, 1, 32'h0000_0100, 32'h0, 1, 32'h8001_8234,
            32'h0000_0100, 4'b0011, 32'h0, 32'h0000_8234);
    do_xfer("lb_101",  1, 0, 2'b00, 0, 32'h0000_0101, 32'h0, 0, 32'h0000_7F00,
            32'h0000_0100, 4'b0010, 32'h0, 32'h0000_007F);
    do_xfer("sb_201",  0, 1, 2'b00, 0, 32'h0000_0201, 32'h1234_56A5, 0, 32'h0,
            32'h0000_0200, 4'b0010, 32'hA5A5_A5A5, 32'h0);
    do_xfer("lw11_200", 1, 0, 2'b11, 0, 32'h0000_0200, 32'h0, 3, 32'h1234_5678,
            32'h0000_0200, 4'b1111, 32'h0, 32'h1234_5678);
    do_xfer("rw_both", 1, 1, 2'b10, 0, 32'h0000_0040, 32'h1122_3344, 0, 32'hFFFF_FFFF,
            32'h0000_0040, 4'b1111, 32'h1122_3344, 32'h0);

    do_misaligned("lw_101_mis", 1, 0, 2'b10, 32'h0000_0101);
    do_misaligned("sh_103_mis", 0, 1, 2'b01, 32'h0000_0103);

    // Timeout: no ack at all.
    @(posedge clock); #2;
    b.name = "timeout"; b.we = 0; b.addr = 32'h0000_0800; b.wdata = 0;
    b.chk_wdata = 0; b.be = 4'b1111; b.len = 16;
    bus_q.push_back(b);
    e.name = "timeout"; e.is_addr_err = 0; e.bus_err = 1; e.data = 0; e.at_cyc = cyc + 17;
    resp_q.push_back(e);
    drive_req(1, 0, 2'b10, 0, 32'h0000_0800, 0);
    @(posedge clock); #2;
    idle_inputs();
    repeat (20) @(posedge clock);
    #2;
    // Stray ack while idle must not produce anything.
    bus_ack = 1;
    @(posedge clock); #2;
    bus_ack = 0;
    repeat (2) @(posedge clock);

    // Reset two cycles into REQ.
    #2;
    b.name = "rst_req"; b.we = 0; b.addr = 32'h0000_0300; b.wdata = 0;
    b.chk_wdata = 0; b.be = 4'b1111; b.len = 2;
    bus_q.push_back(b);
    drive_req(1, 0, 2'b10, 0, 32'h0000_0300, 0);
    @(posedge clock); #2;
    idle_inputs();
    @(posedge clock); #2;
    reset = 1;
    #1 check("rst_stall", {31'b0, Mem_stall}, 32'd0);
    @(posedge clock); #2;
    reset = 0;
    check("rst_bus_req", {31'b0, bus_req}, 32'd0);
    repeat (2) @(posedge clock);

    do_xfer("lw_after_rst", 1, 0, 2'b10, 0, 32'h0000_0300, 32'h0, 0, 32'hCAFE_F00D,
            32'h0000_0300, 4'b1111, 32'h0, 32'hCAFE_F00D);

    repeat (3) @(posedge clock);
    #2;
    check("resp_queue_empty", resp_q.size(), 32'd0);
    check("bus_queue_empty", bus_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
